// File: rtl/lpc_pkg.sv
// LPC host shared definitions: cycle-type, SYNC and status codes plus the
// host sequencer state set.
package lpc_pkg;

    localparam logic [3:0] CT_IO_RD        = 4'h0;
    localparam logic [3:0] CT_IO_WR        = 4'h2;
    localparam logic [3:0] START_CODE      = 4'h0;

    localparam logic [3:0] SYNC_READY      = 4'h0;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'h5;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'h6;
    localparam logic [3:0] SYNC_ERROR      = 4'ha;
    localparam logic [3:0] SYNC_NONE       = 4'hf;

    typedef enum logic [1:0] {
        STAT_OK       = 2'd0,
        STAT_SYNC_ERR = 2'd1,
        STAT_ABORT    = 2'd2
    } status_e;

    typedef enum logic [4:0] {
        S_IDLE,
        S_START,
        S_CTDIR,
        S_ADDR3,
        S_ADDR2,
        S_ADDR1,
        S_ADDR0,
        S_WDATA0,
        S_WDATA1,
        S_TAR0,
        S_TAR1,
        S_SYNC,
        S_RDATA0,
        S_RDATA1,
        S_PTAR0,
        S_PTAR1,
        S_ABORT,
        S_ABORT_END,
        S_RESP
    } state_e;

endpackage

// File: rtl/lpc_host.sv
// LPC I/O-cycle initiator: accepts single-byte read/write requests and runs
// them on LAD/LFRAME#, handling SYNC waits, error SYNC, timeout and abort.
module lpc_host
    import lpc_pkg::*;
#(
    parameter int unsigned NORESP_CYCLES = 3,
    parameter int unsigned WAIT_LIMIT    = 255
) (
    input  logic        lpc_clk,
    input  logic        lpc_rst,
    output logic        lpc_frame,
    inout  wire  [3:0]  lpc_data,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [1:0]  rsp_status
);

    localparam logic [7:0] LP_WAIT_LIMIT = 8'(WAIT_LIMIT);
    localparam logic [7:0] LP_NORESP     = 8'(NORESP_CYCLES);

    state_e      r_state;
    state_e      w_next;

    logic        r_write;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_data;
    logic        r_err;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  r_none_cnt;
    logic [1:0]  r_abort_cnt;

    logic        r_frame;
    logic        r_lad_oe;
    logic [3:0]  r_lad_do;
    logic        r_ready;
    logic        r_rsp_valid;
    logic [7:0]  r_rdata;
    logic [1:0]  r_status;

    logic        w_accept;
    logic [3:0]  w_code;
    logic [7:0]  w_wait_inc;
    logic [7:0]  w_none_inc;
    logic        w_sync_done;
    logic        w_sync_wait;
    logic        w_timeout;
    logic        w_frame;
    logic        w_lad_oe;
    logic [3:0]  w_lad_do;

    assign w_accept    = req_valid && r_ready;
    assign w_code      = lpc_data;
    assign w_wait_inc  = r_wait_cnt + 8'd1;
    assign w_none_inc  = r_none_cnt + 8'd1;
    assign w_sync_done = (w_code == SYNC_READY) || (w_code == SYNC_ERROR);
    assign w_sync_wait = (w_code == SYNC_SHORT_WAIT) || (w_code == SYNC_LONG_WAIT);
    assign w_timeout   = (w_wait_inc >= LP_WAIT_LIMIT) ||
                         (!w_sync_wait && (w_none_inc >= LP_NORESP));

    assign lpc_data   = r_lad_oe ? r_lad_do : 4'bz;
    assign lpc_frame  = r_frame;
    assign req_ready  = r_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rdata;
    assign rsp_status = r_status;

    // Sequencer state register.
    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode; bus drive values are derived from the next state so
    // they can be registered and appear during the state they belong to.
    always_comb begin
        w_next   = r_state;
        w_frame  = 1'b1;
        w_lad_oe = 1'b0;
        w_lad_do = 4'h0;
        case (r_state)
            S_IDLE:      if (w_accept) w_next = S_START;
            S_START:     w_next = S_CTDIR;
            S_CTDIR:     w_next = S_ADDR3;
            S_ADDR3:     w_next = S_ADDR2;
            S_ADDR2:     w_next = S_ADDR1;
            S_ADDR1:     w_next = S_ADDR0;
            S_ADDR0:     w_next = r_write ? S_WDATA0 : S_TAR0;
            S_WDATA0:    w_next = S_WDATA1;
            S_WDATA1:    w_next = S_TAR0;
            S_TAR0:      w_next = S_TAR1;
            S_TAR1:      w_next = S_SYNC;
            S_SYNC: begin
                if (w_sync_done) w_next = r_write ? S_PTAR0 : S_RDATA0;
                else if (w_timeout) w_next = S_ABORT;
            end
            S_RDATA0:    w_next = S_RDATA1;
            S_RDATA1:    w_next = S_PTAR0;
            S_PTAR0:     w_next = S_PTAR1;
            S_PTAR1:     w_next = S_RESP;
            S_ABORT:     if (r_abort_cnt == 2'd3) w_next = S_ABORT_END;
            S_ABORT_END: w_next = S_RESP;
            S_RESP:      w_next = w_accept ? S_START : S_IDLE;
            default:     w_next = S_IDLE;
        endcase

        case (w_next)
            S_START:  begin w_frame = 1'b0; w_lad_oe = 1'b1; w_lad_do = START_CODE;     end
            S_CTDIR:  begin w_lad_oe = 1'b1; w_lad_do = r_write ? CT_IO_WR : CT_IO_RD;   end
            S_ADDR3:  begin w_lad_oe = 1'b1; w_lad_do = r_addr[15:12];                   end
            S_ADDR2:  begin w_lad_oe = 1'b1; w_lad_do = r_addr[11:8];                    end
            S_ADDR1:  begin w_lad_oe = 1'b1; w_lad_do = r_addr[7:4];                     end
            S_ADDR0:  begin w_lad_oe = 1'b1; w_lad_do = r_addr[3:0];                     end
            S_WDATA0: begin w_lad_oe = 1'b1; w_lad_do = r_wdata[3:0];                    end
            S_WDATA1: begin w_lad_oe = 1'b1; w_lad_do = r_wdata[7:4];                    end
            S_TAR0:   begin w_lad_oe = 1'b1; w_lad_do = 4'hf;                            end
            S_ABORT:  begin w_frame = 1'b0; w_lad_oe = 1'b1; w_lad_do = 4'hf;            end
            default:  ;
        endcase
    end

    // Request latch, SYNC/abort counters and read-data capture.
    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_data      <= '1;
            r_err       <= 1'b0;
            r_wait_cnt  <= '0;
            r_none_cnt  <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= 1'b0;
            end
            if (r_state == S_TAR1) begin
                r_wait_cnt <= '0;
                r_none_cnt <= '0;
            end else if (r_state == S_SYNC) begin
                r_wait_cnt <= w_wait_inc;
                if (w_code == SYNC_ERROR) r_err <= 1'b1;
                if (w_sync_wait)       r_none_cnt <= '0;
                else if (!w_sync_done) r_none_cnt <= w_none_inc;
            end
            if (r_state == S_RDATA0) r_data[3:0] <= lpc_data;
            if (r_state == S_RDATA1) r_data[7:4] <= lpc_data;
            if (r_state == S_ABORT) r_abort_cnt <= r_abort_cnt + 2'd1;
            else                    r_abort_cnt <= '0;
        end
    end

    // Registered bus drive and response outputs.
    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            r_frame     <= 1'b1;
            r_lad_oe    <= 1'b0;
            r_lad_do    <= 4'h0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 8'hff;
            r_status    <= STAT_OK;
        end else begin
            r_frame     <= w_frame;
            r_lad_oe    <= w_lad_oe;
            r_lad_do    <= w_lad_do;
            r_ready     <= (w_next == S_IDLE) || (w_next == S_RESP);
            r_rsp_valid <= (w_next == S_RESP);
            if (w_next == S_RESP) begin
                if (r_state == S_ABORT_END) begin
                    r_rdata  <= 8'hff;
                    r_status <= STAT_ABORT;
                end else begin
                    r_rdata  <= (r_write || r_err) ? 8'hff : r_data;
                    r_status <= r_err ? STAT_SYNC_ERR : STAT_OK;
                end
            end
        end
    end

endmodule
